// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window scheduler: FSM encoding and size defaults.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        ISSUE    = 3'd2,
        WAIT_RES = 3'd3,
        FIN      = 3'd4
    } state_t;

    localparam int MAX_N_DEF = 8;
    localparam int MAX_M_DEF = 4;

endpackage

// File: rtl/conv_tap_addr.sv
// Maps a padded-map tap position to a row-major feature index, flagging taps in the pad ring.
module conv_tap_addr #(
    parameter int FIW = 6
) (
    input  logic [5:0]     i_pr,
    input  logic [5:0]     i_pc,
    input  logic [2:0]     i_p,
    input  logic [3:0]     i_n,
    output logic [FIW-1:0] o_feat_idx,
    output logic           o_zero
);

    logic [5:0] w_p6;
    logic [5:0] w_hi;
    logic [5:0] w_fr;
    logic [5:0] w_fc;

    always_comb begin
        w_p6   = {3'b0, i_p};
        w_hi   = w_p6 + {2'b0, i_n};
        o_zero = (i_pr < w_p6) | (i_pr >= w_hi) | (i_pc < w_p6) | (i_pc >= w_hi);
        w_fr   = i_pr - w_p6;
        w_fc   = i_pc - w_p6;
        // Pad taps would wrap here; they are forced to 0 instead.
        o_feat_idx = o_zero ? '0 : (FIW'(w_fr) * FIW'(i_n) + FIW'(w_fc));
    end

endmodule

// File: rtl/conv_window_sched.sv
// Walks every output window of the padded feature map and issues one MAC tap per handshake,
// waiting for the datapath's window sum between windows.
module conv_window_sched
    import conv_pkg::*;
#(
    parameter int MAX_N = MAX_N_DEF,
    parameter int MAX_M = MAX_M_DEF,
    parameter int FIW   = 6,
    parameter int KIW   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [3:0]     cfg_n,
    input  logic [2:0]     cfg_m,
    input  logic [2:0]     cfg_stride,
    input  logic [2:0]     cfg_pad,
    output logic           busy,
    output logic           done,
    output logic           cfg_err,
    output logic           tap_valid,
    input  logic           tap_ready,
    output logic [FIW-1:0] tap_feat_idx,
    output logic [KIW-1:0] tap_filt_idx,
    output logic           tap_zero,
    output logic           tap_first,
    output logic           tap_last,
    input  logic           res_valid,
    output logic [3:0]     out_row,
    output logic [3:0]     out_col
);

    state_t r_state, w_state_nxt;

    logic [3:0] r_n;
    logic [2:0] r_m, r_s, r_p;
    logic [2:0] r_r, r_c, w_r_nxt, w_c_nxt;
    logic [4:0] r_wr, r_wc, w_wr_nxt, w_wc_nxt;
    logic [3:0] r_orow, r_ocol, w_orow_nxt, w_ocol_nxt;

    logic [FIW-1:0] r_tap_feat;
    logic [KIW-1:0] r_tap_filt;
    logic           r_tap_zero, r_tap_first, r_tap_last;

    logic [4:0]     w_np;
    logic           w_bad, w_last, w_tap_go;
    logic [5:0]     w_pr, w_pc;
    logic [FIW-1:0] w_feat;
    logic           w_zero;

    assign w_np  = {1'b0, r_n} + {1'b0, r_p, 1'b0};
    assign w_bad = (r_n == 4'd0) || (r_n > 4'(MAX_N)) ||
                   (r_m == 3'd0) || (r_m > 3'(MAX_M)) ||
                   (r_s == 3'd0) || ({2'b0, r_m} > w_np) || (r_p >= r_m);
    assign w_last = (r_r == r_m - 3'd1) && (r_c == r_m - 3'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_r_nxt     = r_r;
        w_c_nxt     = r_c;
        w_wr_nxt    = r_wr;
        w_wc_nxt    = r_wc;
        w_orow_nxt  = r_orow;
        w_ocol_nxt  = r_ocol;
        case (r_state)
            IDLE: if (start) w_state_nxt = CHECK;
            CHECK: begin
                if (w_bad) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_r_nxt     = '0;
                    w_c_nxt     = '0;
                    w_wr_nxt    = '0;
                    w_wc_nxt    = '0;
                    w_orow_nxt  = '0;
                    w_ocol_nxt  = '0;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (tap_ready) begin
                    if (w_last) begin
                        w_r_nxt     = '0;
                        w_c_nxt     = '0;
                        w_state_nxt = WAIT_RES;
                    end else if (r_c == r_m - 3'd1) begin
                        w_c_nxt = '0;
                        w_r_nxt = r_r + 3'd1;
                    end else begin
                        w_c_nxt = r_c + 3'd1;
                    end
                end
            end
            WAIT_RES: begin
                // Window count falls out of these bounds; the last window leaves coordinates untouched.
                if (res_valid) begin
                    if ({1'b0, r_wc} + {3'b0, r_s} + {3'b0, r_m} <= {1'b0, w_np}) begin
                        w_wc_nxt    = r_wc + {2'b0, r_s};
                        w_ocol_nxt  = r_ocol + 4'd1;
                        w_state_nxt = ISSUE;
                    end else if ({1'b0, r_wr} + {3'b0, r_s} + {3'b0, r_m} <= {1'b0, w_np}) begin
                        w_wc_nxt    = '0;
                        w_ocol_nxt  = '0;
                        w_wr_nxt    = r_wr + {2'b0, r_s};
                        w_orow_nxt  = r_orow + 4'd1;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_state_nxt = FIN;
                    end
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Tap fields are precomputed from next-cycle counters so they are registered yet stall-free.
    assign w_pr     = {1'b0, w_wr_nxt} + {3'b0, w_r_nxt};
    assign w_pc     = {1'b0, w_wc_nxt} + {3'b0, w_c_nxt};
    assign w_tap_go = (w_state_nxt == ISSUE);

    conv_tap_addr #(.FIW(FIW)) u_addr (
        .i_pr       (w_pr),
        .i_pc       (w_pc),
        .i_p        (r_p),
        .i_n        (r_n),
        .o_feat_idx (w_feat),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n         <= '0;
            r_m         <= '0;
            r_s         <= '0;
            r_p         <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_wr        <= '0;
            r_wc        <= '0;
            r_orow      <= '0;
            r_ocol      <= '0;
            r_tap_feat  <= '0;
            r_tap_filt  <= '0;
            r_tap_zero  <= 1'b0;
            r_tap_first <= 1'b0;
            r_tap_last  <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_n <= cfg_n;
                r_m <= cfg_m;
                r_s <= cfg_stride;
                r_p <= cfg_pad;
            end
            r_r         <= w_r_nxt;
            r_c         <= w_c_nxt;
            r_wr        <= w_wr_nxt;
            r_wc        <= w_wc_nxt;
            r_orow      <= w_orow_nxt;
            r_ocol      <= w_ocol_nxt;
            r_tap_feat  <= w_tap_go ? w_feat : '0;
            r_tap_filt  <= w_tap_go ? (KIW'(w_r_nxt) * KIW'(r_m) + KIW'(w_c_nxt)) : '0;
            r_tap_zero  <= w_tap_go & w_zero;
            r_tap_first <= w_tap_go & (w_r_nxt == 3'd0) & (w_c_nxt == 3'd0);
            r_tap_last  <= w_tap_go & (w_r_nxt == r_m - 3'd1) & (w_c_nxt == r_m - 3'd1);
        end
    end

    assign busy         = (r_state == CHECK) || (r_state == ISSUE) || (r_state == WAIT_RES);
    assign done         = (r_state == FIN);
    assign cfg_err      = (r_state == CHECK) && w_bad;
    assign tap_valid    = (r_state == ISSUE);
    assign tap_feat_idx = r_tap_feat;
    assign tap_filt_idx = r_tap_filt;
    assign tap_zero     = r_tap_zero;
    assign tap_first    = r_tap_first;
    assign tap_last     = r_tap_last;
    assign out_row      = r_orow;
    assign out_col      = r_ocol;

endmodule

// File: tb/tb_conv_window_sched.sv
// Scoreboard bench for conv_window_sched: a reference walk of the padded map queues expected taps.
module tb_conv_window_sched;

    typedef struct packed {
        logic [5:0] feat;
        logic [3:0] filt;
        logic       zero;
        logic       first;
        logic       last;
        logic [3:0] orow;
        logic [3:0] ocol;
    } tap_t;

    logic       clk = 1'b0;
    logic       rst, start, tap_ready, res_valid;
    logic [3:0] cfg_n;
    logic [2:0] cfg_m, cfg_stride, cfg_pad;
    logic       busy, done, cfg_err, tap_valid, tap_zero, tap_first, tap_last;
    logic [5:0] tap_feat_idx;
    logic [3:0] tap_filt_idx, out_row, out_col;

    tap_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    conv_window_sched dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_n        (cfg_n),
        .cfg_m        (cfg_m),
        .cfg_stride   (cfg_stride),
        .cfg_pad      (cfg_pad),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .tap_valid    (tap_valid),
        .tap_ready    (tap_ready),
        .tap_feat_idx (tap_feat_idx),
        .tap_filt_idx (tap_filt_idx),
        .tap_zero     (tap_zero),
        .tap_first    (tap_first),
        .tap_last     (tap_last),
        .res_valid    (res_valid),
        .out_row      (out_row),
        .out_col      (out_col)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model(input int n, input int m, input int s, input int p, output int nwin);
        tap_t t;
        int   np, pr, pc;
        np   = n + 2 * p;
        nwin = 0;
        for (int orow = 0; orow * s + m <= np; orow++) begin
            for (int ocol = 0; ocol * s + m <= np; ocol++) begin
                nwin++;
                for (int r = 0; r < m; r++) begin
                    for (int c = 0; c < m; c++) begin
                        pr      = orow * s + r;
                        pc      = ocol * s + c;
                        t.zero  = (pr < p) || (pr >= p + n) || (pc < p) || (pc >= p + n);
                        t.feat  = t.zero ? 6'd0 : 6'((pr - p) * n + (pc - p));
                        t.filt  = 4'(r * m + c);
                        t.first = (r == 0) && (c == 0);
                        t.last  = (r == m - 1) && (c == m - 1);
                        t.orow  = 4'(orow);
                        t.ocol  = 4'(ocol);
                        exp_q.push_back(t);
                    end
                end
            end
        end
    endtask

    task automatic run(input int n, input int m, input int s, input int p,
                       input bit bp, input bit bad, input int abort_at, input bit poke);
        int   k, kdone, ntap, ndone, nerr, nvalid, pend, nwin, ntot;
        bit   fin, rv_prev;
        tap_t t;
        exp_q.delete();
        nwin = 0; ntap = 0; ndone = 0; nerr = 0; nvalid = 0; pend = 0; kdone = 0; fin = 0;
        if (!bad) model(n, m, s, p, nwin);
        ntot = exp_q.size();
        @(negedge clk);
        cfg_n = 4'(n); cfg_m = 3'(m); cfg_stride = 3'(s); cfg_pad = 3'(p);
        start = 1'b1; tap_ready = 1'b0; res_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cfg_n = 4'd7; cfg_m = 3'd1; cfg_stride = 3'd3; cfg_pad = 3'd0;
        k = 1;
        while (!fin && k <= 1000) begin
            if (k > 1) @(negedge clk);
            rv_prev   = res_valid;
            res_valid = 1'b0;
            if (k == 1) begin
                chk("busy_after_start", busy, 1);
                chk("cfg_err_k1", cfg_err, bad);
            end
            if (k == 2 && !bad) chk("start_to_tap", tap_valid, 1);
            if (rv_prev && exp_q.size() > 0) chk("res_to_tap", tap_valid, 1);
            if (poke) begin
                start = (k == 5);
                if (k == 3) res_valid = 1'b1;
            end
            if (done) begin
                ndone++; kdone = k; fin = 1;
                chk("busy_at_done", busy, 0);
            end
            if (cfg_err) begin
                nerr++; fin = 1;
            end
            if (tap_valid) begin
                nvalid++;
                if (exp_q.size() == 0) chk("spurious_tap", tap_valid, 0);
                else chk($sformatf("tap%0d", ntap),
                         {tap_feat_idx, tap_filt_idx, tap_zero, tap_first, tap_last, out_row, out_col},
                         exp_q[0]);
                if (ntap == abort_at) begin
                    rst = 1'b0;
                    #1;
                    chk("rst_outputs", {busy, done, cfg_err, tap_valid, tap_feat_idx, tap_filt_idx,
                                        tap_zero, tap_first, tap_last, out_row, out_col}, 0);
                    return;
                end
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) res_valid = 1'b1;
            end
            tap_ready = bp ? k[0] : 1'b1;
            if (tap_valid && tap_ready) begin
                ntap++;
                if (exp_q.size() > 0) begin
                    t = exp_q.pop_front();
                    if (t.last) pend = 2;
                end
            end
            k++;
        end
        start = 1'b0; res_valid = 1'b0; tap_ready = 1'b0;
        chk("finished_in_budget", fin, 1);
        chk("taps_issued", ntap, ntot);
        chk("done_pulses", ndone, !bad);
        chk("err_pulses", nerr, bad);
        chk("queue_left", exp_q.size(), 0);
        if (!bad && !bp) chk("done_cycle", kdone, 2 + nwin * (m * m + 2));
        if (bad) chk("err_no_tap", nvalid, 0);
        repeat (3) begin
            @(negedge clk);
            chk("idle_quiet", {busy, done, cfg_err, tap_valid}, 0);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; tap_ready = 1'b0; res_valid = 1'b0;
        cfg_n = '0; cfg_m = '0; cfg_stride = '0; cfg_pad = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", {busy, done, cfg_err, tap_valid, tap_feat_idx, tap_filt_idx,
                            tap_zero, tap_first, tap_last, out_row, out_col}, 0);
        rst = 1'b1;

        run(3, 2, 1, 0, 1'b0, 1'b0, -1, 1'b1);   // basic walk with stray start/res_valid
        run(3, 2, 1, 1, 1'b0, 1'b0, -1, 1'b0);   // padded, 16 windows
        run(3, 2, 2, 0, 1'b0, 1'b0, -1, 1'b0);   // single window
        run(3, 2, 1, 0, 1'b1, 1'b0, -1, 1'b0);   // backpressure
        run(2, 4, 1, 0, 1'b0, 1'b1, -1, 1'b0);   // m > np
        run(3, 2, 0, 0, 1'b0, 1'b1, -1, 1'b0);   // s == 0
        run(3, 2, 1, 2, 1'b0, 1'b1, -1, 1'b0);   // p >= m

        run(3, 2, 1, 0, 1'b0, 1'b0, 6, 1'b0);    // reset during 3rd tap of window (0,1)
        start = 1'b0; tap_ready = 1'b0; res_valid = 1'b0;
        @(negedge clk);
        chk("busy_in_reset", busy, 0);
        rst = 1'b1;
        run(3, 2, 1, 0, 1'b0, 1'b0, -1, 1'b0);   // clean restart from window (0,0)

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
